// File: rtl/binary_to_decimal_decoder.sv
// 4-bit binary to 10-bit one-hot decimal decoder with a DEPTH-entry result FIFO.
// Out-of-range codes (10-15) produce an all-zero result flagged by dec_err and are counted.
module binary_to_decimal_decoder #(
    parameter int DEPTH = 4,
    parameter int CNT_W = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     bin_valid,
    output logic                     bin_ready,
    input  logic [3:0]               Binary,
    output logic                     dec_valid,
    input  logic                     dec_ready,
    output logic [9:0]               Decimal,
    output logic                     dec_err,
    output logic [CNT_W-1:0]         err_count,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int PW = $clog2(DEPTH);
    localparam int LW = PW + 1;

    // Handshakes: a transfer happens on a rising edge where valid and ready are both 1;
    // ready never depends on the opposite side's valid/ready, only on registered occupancy.
    logic [10:0]   mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic          push;
    logic          pop;
    logic          code_err;
    logic [9:0]    dec_onehot;

    always_comb begin
        code_err   = 1'b0;
        dec_onehot = '0;
        if (Binary > 4'd9) begin
            code_err = 1'b1;
        end else begin
            dec_onehot = 10'd1 << Binary;
        end
    end

    always_comb begin
        bin_ready = 1'b0;
        dec_valid = 1'b0;
        Decimal   = '0;
        dec_err   = 1'b0;
        if (!rst) begin
            bin_ready = (level < LW'(DEPTH));
            dec_valid = (level != '0);
        end
        // The head is masked whenever nothing valid is presented.
        if (dec_valid) begin
            Decimal = mem[rd_ptr][10:1];
            dec_err = mem[rd_ptr][0];
        end
    end

    assign push = bin_valid && bin_ready;
    assign pop  = dec_valid && dec_ready;

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= {dec_onehot, code_err};
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            level     <= '0;
            err_count <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase
            if (push && code_err && (err_count != '1)) begin
                err_count <= err_count + 1'b1;
            end
        end
    end

endmodule

// File: doc/binary_to_decimal_decoder.md
BINARY_TO_DECIMAL_DECODER -- requirements
Module: binary_to_decimal_decoder

Interface
REQ-001 SHALL have parameter DEPTH, default 4: output FIFO entries; power of two, minimum 2.
REQ-002 SHALL have parameter CNT_W, default 8: width of the error counter.
REQ-003 SHALL use one clock; reset is synchronous and active-high.
REQ-004 SHALL have port clk, input, 1 bit: rising-edge clock for all state.
REQ-005 SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-006 SHALL have port bin_valid, input, 1 bit: the Binary code is valid.
REQ-007 SHALL have port bin_ready, output, 1 bit: the block can accept a code.
REQ-008 SHALL have port Binary, input, 4 bits: binary code to decode.
REQ-009 SHALL have port dec_valid, output, 1 bit: the FIFO head holds a result.
REQ-010 SHALL have port dec_ready, input, 1 bit: the consumer accepts the head.
REQ-011 SHALL have port Decimal, output, 10 bits: one-hot decimal result.
REQ-012 SHALL have port dec_err, output, 1 bit: the head entry came from an out-of-range code.
REQ-013 SHALL have port err_count, output, CNT_W bits: number of accepted out-of-range codes.
REQ-014 SHALL have port level, output, log2(DEPTH)+1 bits: current FIFO occupancy.

Function
REQ-015 SHALL accept a code (push) in a cycle where bin_valid=1 and bin_ready=1.
REQ-016 SHALL drive bin_ready=1 exactly when level<DEPTH and rst=0; it depends only on registered state, never on dec_ready.
REQ-017 SHALL decode a code n of 0-9 to Decimal = 1<<n (bit n set only) with dec_err=0.
REQ-018 SHALL decode codes 10-15 to Decimal=10'b0 with dec_err=1; such an entry is still pushed and delivered.
REQ-019 SHALL store each decoded {Decimal, dec_err} in a DEPTH-entry circular FIFO; read and write pointers wrap modulo DEPTH.
REQ-020 SHALL drive dec_valid=1 exactly when level>0, and present the FIFO head on Decimal/dec_err.
REQ-021 SHALL drive Decimal=0 and dec_err=0 whenever dec_valid=0.
REQ-022 SHALL pop the head in a cycle where dec_valid=1 and dec_ready=1.
REQ-023 SHALL have a latency of 1 cycle: a code accepted at edge k appears with dec_valid=1 after edge k, with no combinational input-to-output path.
REQ-024 SHALL, on a simultaneous push and pop, leave level unchanged and preserve order.
REQ-025 SHALL, when full, drive bin_ready=0; a pop in that cycle does not allow a push in the same cycle.
REQ-026 SHALL hold Decimal/dec_err stable while dec_valid=1 and dec_ready=0.
REQ-027 SHALL ignore bin_valid while bin_ready=0; no push occurs and err_count does not change.
REQ-028 SHALL increment err_count by 1 on each accepted code >9; err_count saturates at 2^CNT_W-1 and does not wrap.
REQ-029 SHALL deliver results in strict acceptance (FIFO) order.

Reset
REQ-030 SHALL, while rst=1 at a clock edge, clear level, the pointers and err_count to 0.
REQ-031 SHALL drive, during and after reset, dec_valid=0, Decimal=0, dec_err=0 and bin_ready=0; bin_ready=1 from the first cycle after rst is low.
REQ-032 SHALL, on reset mid-operation, discard all FIFO contents; no pre-reset entry is ever output.

Verification
REQ-033 SHALL pass this sweep: push Binary=0..9 one per cycle with dec_ready=1 -> Decimal = 1,2,4,...,512 each one cycle later, dec_err=0, err_count=0.
REQ-034 SHALL pass this error test: push 10, 15, 3 -> outputs 0/err=1, 0/err=1, 8/err=0; err_count=2.
REQ-035 SHALL pass this backpressure test: with dec_ready=0, push 5 codes with DEPTH=4 -> 4 accepted, bin_ready=0 at level=4, head holds 1<<first code; then release dec_ready -> 4 outputs in order.
REQ-036 SHALL pass this full-throughput test: with the FIFO at level=2, push and pop every cycle for 8 cycles -> level stays 2 and the order is correct.
REQ-037 SHALL pass this saturation test: with CNT_W=2, push code 12 five times -> err_count sticks at 3.
REQ-038 SHALL pass this reset test: assert rst for 1 cycle at level=3 -> next cycle level=0, dec_valid=0, err_count=0, and no stale data afterwards.
